// File: rtl/mul_dot_accum.sv
// Captures one multiplier product per slot, sums N_TERMS of them and offers the
// sum on a valid/ready output, flagging sums dropped while the consumer stalls.
module mul_dot_accum #(
  parameter int IN_W    = 10,
  parameter int PERIOD  = 5,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = IN_W + $clog2(N_TERMS),
  localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1,
  localparam int TI_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  prod_in,
  input  logic             clear,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [TI_W-1:0]  term_idx,
  output logic             overrun
);

  // Output handshake: a sum transfers on any edge where sum_valid && sum_ready.
  // A new sum may load on that same edge, so the slot never bubbles.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t             state, state_next;
  logic [PH_W-1:0]   phase;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  result;
  logic              cap, last, slot_free, load, drop;

  assign prod_ext  = ACC_W'(prod_in);
  assign cap       = (phase == PH_W'(PERIOD - 1)) && !clear;
  assign last      = (term_idx == TI_W'(N_TERMS - 1));
  assign result    = (term_idx == '0) ? prod_ext : acc + prod_ext;
  assign slot_free = (state == EMPTY) || sum_ready;
  assign load      = cap && last && slot_free;
  assign drop      = cap && last && !slot_free;
  assign sum_valid = (state == FULL);

  // Phase tracks the multiplier's bit counter; clear must not disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == PH_W'(PERIOD - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc      <= '0;
      term_idx <= '0;
    end else if (cap) begin
      acc      <= result;
      term_idx <= last ? '0 : term_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      sum   <= '0;
    end else begin
      state <= state_next;
      if (load) sum <= result;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (load) state_next = FULL;
      FULL:    if (!load && sum_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_dot_accum.sv
// Bench for mul_dot_accum: random products checked against a slot-level model
// that collects captured products in a queue and sums every N_TERMS of them.
module tb_mul_dot_accum;
  localparam int IN_W    = 10;
  localparam int PERIOD  = 5;
  localparam int N_TERMS = 4;
  localparam int ACC_W   = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [IN_W-1:0]  prod_in = '0;
  logic             clear = 1'b0;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic [1:0]       term_idx;
  logic             overrun;

  int total = 0;
  int bad = 0;

  // behavioural reference state
  int               m_cyc = 0;
  logic [IN_W-1:0]  terms[$];
  logic [ACC_W-1:0] m_sum = '0;
  logic             m_valid = 1'b0;
  logic             m_over = 1'b0;

  mul_dot_accum #(.IN_W(IN_W), .PERIOD(PERIOD), .N_TERMS(N_TERMS)) dut (
    .clk(clk), .reset(reset), .prod_in(prod_in), .clear(clear),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .term_idx(term_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic bit prod_slot();
    return (m_cyc % PERIOD) == PERIOD - 1;
  endfunction

  // Advance the model with the inputs now applied, then take one clock edge.
  task automatic tick();
    int  s;
    bit  taken, loaded;
    if (reset) begin
      m_cyc = 0; terms.delete(); m_sum = '0; m_valid = 1'b0; m_over = 1'b0;
    end else begin
      taken  = m_valid && sum_ready;
      loaded = 1'b0;
      if (clear) begin
        terms.delete();
        m_over = 1'b0;
      end else if (prod_slot()) begin
        terms.push_back(prod_in);
        if (terms.size() == N_TERMS) begin
          s = 0;
          foreach (terms[i]) s += int'(terms[i]);
          terms.delete();
          if (!m_valid || sum_ready) begin
            m_sum = ACC_W'(s);
            loaded = 1'b1;
          end else begin
            m_over = 1'b1;
          end
        end
      end
      if (loaded) m_valid = 1'b1;
      else if (taken) m_valid = 1'b0;
      m_cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sum_ready = 1'b1;
    prod_in = IN_W'($urandom_range(0, 1023));
    tick(); tick();
    total++; if (sum !== 12'd0) begin bad++; $display("FAIL reset_sum: got %0d want 0", sum); end
    total++; if (sum_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", sum_valid); end
    total++; if (term_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", term_idx); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
  endtask

  task automatic test_fixed_3x5();
    do_reset();
    sum_ready = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      prod_in = prod_slot() ? IN_W'(15) : IN_W'($urandom_range(0, 1023));
      tick();
      total++;
      if ({sum_valid, sum, overrun, term_idx} !== {m_valid, m_sum, m_over, 2'(terms.size())}) begin
        bad++;
        $display("FAIL fixed_model e=%0d: got v=%b s=%0d o=%b i=%0d want v=%b s=%0d o=%b i=%0d",
                 e, sum_valid, sum, overrun, term_idx, m_valid, m_sum, m_over, terms.size());
      end
      if (e == 20 || e == 40) begin
        total++;
        if (sum_valid !== 1'b1 || sum !== 12'h03C) begin
          bad++; $display("FAIL fixed_sum e=%0d: got v=%b s=%0d want v=1 s=60", e, sum_valid, sum);
        end
      end
      if (e == 19 || e == 21) begin
        total++;
        if (sum_valid !== 1'b0) begin bad++; $display("FAIL fixed_pulse e=%0d: got v=%b want 0", e, sum_valid); end
      end
    end
  endtask

  task automatic test_max_no_wrap();
    logic [1:0] exp_idx;
    do_reset();
    sum_ready = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      prod_in = prod_slot() ? IN_W'(961) : IN_W'($urandom_range(0, 1023));
      tick();
      total++;
      if ({sum_valid, sum, overrun, term_idx} !== {m_valid, m_sum, m_over, 2'(terms.size())}) begin
        bad++;
        $display("FAIL max_model e=%0d: got v=%b s=%0d i=%0d want v=%b s=%0d i=%0d",
                 e, sum_valid, sum, term_idx, m_valid, m_sum, terms.size());
      end
      if (e % 5 == 0) begin
        exp_idx = 2'((e / 5) % 4);
        total++;
        if (term_idx !== exp_idx) begin bad++; $display("FAIL max_idx e=%0d: got %0d want %0d", e, term_idx, exp_idx); end
      end
    end
    total++;
    if (sum_valid !== 1'b1 || sum !== 12'hF04) begin
      bad++; $display("FAIL max_sum: got v=%b s=%0d want v=1 s=3844", sum_valid, sum);
    end
  endtask

  task automatic test_overrun();
    int first = 0;
    int k = 0;
    logic [IN_W-1:0] p;
    do_reset();
    sum_ready = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      p = IN_W'($urandom_range(0, 1023));
      if (prod_slot()) begin
        if (k < 4) first += int'(p);
        k++;
      end
      prod_in = p;
      tick();
      total++;
      if ({sum_valid, sum, overrun, term_idx} !== {m_valid, m_sum, m_over, 2'(terms.size())}) begin
        bad++;
        $display("FAIL ovr_model e=%0d: got v=%b s=%0d o=%b want v=%b s=%0d o=%b",
                 e, sum_valid, sum, overrun, m_valid, m_sum, m_over);
      end
    end
    total++;
    if (sum_valid !== 1'b1 || sum !== ACC_W'(first) || overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_hold: got v=%b s=%0d o=%b want v=1 s=%0d o=1", sum_valid, sum, overrun, first);
    end
    sum_ready = 1'b1;
    tick();
    total++;
    if (sum_valid !== 1'b0 || overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_drain: got v=%b o=%b want v=0 o=1", sum_valid, overrun);
    end
    sum_ready = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (overrun !== 1'b0 || term_idx !== 2'd0) begin
      bad++; $display("FAIL ovr_clear: got o=%b i=%0d want o=0 i=0", overrun, term_idx);
    end
  endtask

  task automatic test_back_to_back();
    int s1 = 0;
    int s2 = 0;
    int k = 0;
    logic [IN_W-1:0] p;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      sum_ready = (e == 40);
      p = IN_W'($urandom_range(0, 1023));
      if (prod_slot()) begin
        if (k < 4) s1 += int'(p); else s2 += int'(p);
        k++;
      end
      prod_in = p;
      tick();
      total++;
      if ({sum_valid, sum, overrun, term_idx} !== {m_valid, m_sum, m_over, 2'(terms.size())}) begin
        bad++;
        $display("FAIL b2b_model e=%0d: got v=%b s=%0d o=%b want v=%b s=%0d o=%b",
                 e, sum_valid, sum, overrun, m_valid, m_sum, m_over);
      end
      if (e == 20) begin
        total++;
        if (sum_valid !== 1'b1 || sum !== ACC_W'(s1)) begin
          bad++; $display("FAIL b2b_first: got v=%b s=%0d want v=1 s=%0d", sum_valid, sum, s1);
        end
      end
    end
    total++;
    if (sum_valid !== 1'b1 || sum !== ACC_W'(s2) || overrun !== 1'b0) begin
      bad++; $display("FAIL b2b_replace: got v=%b s=%0d o=%b want v=1 s=%0d o=0", sum_valid, sum, overrun, s2);
    end
    sum_ready = 1'b0;
  endtask

  task automatic test_clear();
    int exp_sum = 0;
    logic [IN_W-1:0] p;
    do_reset();
    sum_ready = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      clear = (e == 15);
      p = IN_W'($urandom_range(0, 1023));
      if (e > 15 && prod_slot()) exp_sum += int'(p);
      prod_in = p;
      tick();
      total++;
      if ({sum_valid, sum, overrun, term_idx} !== {m_valid, m_sum, m_over, 2'(terms.size())}) begin
        bad++;
        $display("FAIL clr_model e=%0d: got v=%b s=%0d i=%0d want v=%b s=%0d i=%0d",
                 e, sum_valid, sum, term_idx, m_valid, m_sum, terms.size());
      end
      if (e == 15 || e == 20) begin
        total++;
        if (sum_valid !== 1'b0) begin bad++; $display("FAIL clr_novalid e=%0d: got v=%b want 0", e, sum_valid); end
      end
      if (e == 15) begin
        total++;
        if (term_idx !== 2'd0) begin bad++; $display("FAIL clr_idx: got %0d want 0", term_idx); end
      end
    end
    clear = 1'b0;
    total++;
    if (sum_valid !== 1'b1 || sum !== ACC_W'(exp_sum)) begin
      bad++; $display("FAIL clr_sum: got v=%b s=%0d want v=1 s=%0d", sum_valid, sum, exp_sum);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sum_ready = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      prod_in = IN_W'($urandom_range(1, 1023));
      tick();
    end
    total++;
    if (sum_valid !== 1'b1) begin bad++; $display("FAIL rmid_pending: got v=%b want 1", sum_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({sum_valid, sum, overrun, term_idx} !== 16'd0) begin
      bad++; $display("FAIL rmid_clear: got v=%b s=%0d o=%b i=%0d want all 0", sum_valid, sum, overrun, term_idx);
    end
    sum_ready = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      prod_in = IN_W'($urandom_range(0, 1023));
      tick();
      total++;
      if ({sum_valid, sum, overrun, term_idx} !== {m_valid, m_sum, m_over, 2'(terms.size())}) begin
        bad++;
        $display("FAIL rmid_model e=%0d: got v=%b s=%0d want v=%b s=%0d", e, sum_valid, sum, m_valid, m_sum);
      end
      if (e == 19 || e == 20) begin
        total++;
        if (sum_valid !== (e == 20)) begin
          bad++; $display("FAIL rmid_latency e=%0d: got v=%b want %b", e, sum_valid, (e == 20));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_3x5();
    test_max_no_wrap();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
